// File: rtl/sdu_dump_seq.sv
// sdu_dump_seq
//   Dump sequencer for the serial debug unit. A start command walks addr
//   over a window of RF, DM or IM, captures each 32-bit word and streams it
//   to the UART TX byte interface as uppercase ASCII hex. Words on a line
//   are separated by a space, and each line ends with CR LF.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   start             1-cycle command pulse, only accepted while idle
//   src               source select: 0=RF, 1=DM, 2=IM, 3=reserved (reads 0)
//   base, count       first word address and number of words, captured on start
//   abort             stop the dump at the next byte boundary
//   busy, done        busy while a dump runs, 1-cycle done pulse at its end
//   addr              read address to RF/DM/IM (owned by this block while busy)
//   dout_rf/dm/im     read data, valid RD_LAT cycles after an addr change
//   d_tx, vld_tx      byte to the TX side and its valid
//   rdy_tx            TX ready; a byte moves when vld_tx & rdy_tx at an edge
module sdu_dump_seq #(
  parameter int RD_LAT         = 1,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  src,
  input  logic [31:0] base,
  input  logic [15:0] count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [31:0] addr,
  input  logic [31:0] dout_rf,
  input  logic [31:0] dout_dm,
  input  logic [31:0] dout_im,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, HEX, SEP, CR, LF, FIN} state_t;

  state_t      state;
  logic [31:0] base_q;
  logic [15:0] count_q;
  logic [1:0]  src_q;
  logic [15:0] idx;
  logic [4:0]  line_cnt;
  logic [2:0]  wait_cnt;
  logic [2:0]  nib;
  logic [31:0] word;
  logic        abort_q;

  logic [31:0] rd_word;
  logic        xfer;
  logic        abort_pend;
  logic        last_word;

  // ASCII for one hex digit, uppercase letters.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h37 + {4'h0, n};
  endfunction

  // Read data mux driven by the source captured at start, so a change on
  // src mid-dump cannot switch memories underneath the walk.
  always_comb begin
    rd_word = 32'h0;
    case (src_q)
      2'd0:    rd_word = dout_rf;
      2'd1:    rd_word = dout_dm;
      2'd2:    rd_word = dout_im;
      default: rd_word = 32'h0;
    endcase
  end

  assign xfer       = vld_tx & rdy_tx;
  // The live abort input is ORed in so that an abort is acted on in the
  // same cycle it arrives, not one cycle later.
  assign abort_pend = abort_q | abort;
  assign last_word  = (idx == count_q - 16'd1);

  // Main sequencer. Every output is registered. Abort is only acted on
  // when no byte is being offered, or on the edge where the offered byte
  // transfers, so a byte is never withdrawn once vld_tx is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      addr     <= 32'h0;
      d_tx     <= 8'h0;
      vld_tx   <= 1'b0;
      base_q   <= 32'h0;
      count_q  <= 16'h0;
      src_q    <= 2'd0;
      idx      <= 16'h0;
      line_cnt <= 5'd0;
      wait_cnt <= 3'd0;
      nib      <= 3'd0;
      word     <= 32'h0;
      abort_q  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy) abort_q <= abort_q | abort;

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base;
            count_q  <= count;
            src_q    <= src;
            idx      <= 16'h0;
            line_cnt <= 5'd0;
            abort_q  <= 1'b0;
            busy     <= 1'b1;
            state    <= (count == 16'h0) ? FIN : ADDR;
          end
        end

        ADDR: begin
          if (abort_pend) begin
            state <= FIN;
          end else begin
            addr     <= base_q + {16'h0, idx};
            wait_cnt <= 3'd0;
            state    <= WAIT;
          end
        end

        // Hold off until the read data for the new address has settled,
        // then load the word and offer its first digit in the same edge.
        WAIT: begin
          if (abort_pend) begin
            state <= FIN;
          end else if (wait_cnt == 3'(RD_LAT)) begin
            word     <= {rd_word[27:0], 4'h0};
            d_tx     <= hex_char(rd_word[31:28]);
            vld_tx   <= 1'b1;
            nib      <= 3'd0;
            line_cnt <= line_cnt + 5'd1;
            state    <= HEX;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        // word is kept pre-shifted so its top nibble is always the next
        // digit to send.
        HEX: begin
          if (xfer) begin
            if (abort_pend) begin
              vld_tx <= 1'b0;
              state  <= FIN;
            end else if (nib == 3'd7) begin
              if (last_word || line_cnt == 5'(WORDS_PER_LINE)) begin
                d_tx  <= 8'h0D;
                state <= CR;
              end else begin
                d_tx  <= 8'h20;
                state <= SEP;
              end
            end else begin
              d_tx <= hex_char(word[31:28]);
              word <= {word[27:0], 4'h0};
              nib  <= nib + 3'd1;
            end
          end
        end

        SEP: begin
          if (xfer) begin
            vld_tx <= 1'b0;
            if (abort_pend) begin
              state <= FIN;
            end else begin
              idx   <= idx + 16'd1;
              state <= ADDR;
            end
          end
        end

        CR: begin
          if (xfer) begin
            if (abort_pend) begin
              vld_tx <= 1'b0;
              state  <= FIN;
            end else begin
              d_tx  <= 8'h0A;
              state <= LF;
            end
          end
        end

        LF: begin
          if (xfer) begin
            vld_tx   <= 1'b0;
            line_cnt <= 5'd0;
            if (abort_pend || last_word) begin
              state <= FIN;
            end else begin
              idx   <= idx + 16'd1;
              state <= ADDR;
            end
          end
        end

        FIN: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          abort_q <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdu_dump_seq.sv
// tb_sdu_dump_seq
//   Directed bench for sdu_dump_seq. It models the three memories with one
//   cycle of read latency, builds the expected byte stream independently,
//   and checks bytes, handshake stability, done/busy timing, address wrap,
//   abort and reset behaviour.
module tb_sdu_dump_seq;

  localparam int RD_LAT = 1;
  localparam int WPL    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  src;
  logic [31:0] base;
  logic [15:0] count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] addr;
  logic [31:0] dout_rf;
  logic [31:0] dout_dm;
  logic [31:0] dout_im;
  logic [7:0]  d_tx;
  logic        vld_tx;
  logic        rdy_tx = 1'b1;

  int checks   = 0;
  int errors   = 0;
  int rdy_mode = 0;
  int done_cnt = 0;
  int vld_seen = 0;

  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] last_addr = 32'h0;
  logic        held = 1'b0;
  logic [7:0]  held_byte = 8'h0;
  string       hexdig = "0123456789ABCDEF";

  sdu_dump_seq #(.RD_LAT(RD_LAT), .WORDS_PER_LINE(WPL)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .base(base), .count(count),
    .abort(abort), .busy(busy), .done(done), .addr(addr),
    .dout_rf(dout_rf), .dout_dm(dout_dm), .dout_im(dout_im),
    .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rfWord(input logic [31:0] a);
    if (a == 32'h0)      return 32'h0000_00AB;
    else if (a == 32'h1) return 32'h1234_5678;
    else                 return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] dmWord(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] imWord(input logic [31:0] a);
    return ~a ^ 32'h0F0F_0000;
  endfunction

  function automatic logic [31:0] memWord(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    return rfWord(a);
      2'd1:    return dmWord(a);
      2'd2:    return imWord(a);
      default: return 32'h0;
    endcase
  endfunction

  // Memories with one registered read stage.
  always @(posedge clk) begin
    dout_rf <= rfWord(addr);
    dout_dm <= dmWord(addr);
    dout_im <= imWord(addr);
  end

  // TX ready: always high, or high about 30% of cycles.
  always @(negedge clk) begin
    if (rdy_mode == 0) rdy_tx = 1'b1;
    else               rdy_tx = ($urandom_range(0, 9) < 3);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transfer monitor: captures accepted bytes, done pulses, address changes,
  // and checks that a stalled byte stays put until it is taken.
  always @(posedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("hold_vld", 32'(vld_tx), 32'd1);
        checkOutput("hold_data", 32'(d_tx), 32'(held_byte));
      end
      held      = vld_tx && !rdy_tx;
      held_byte = d_tx;
      if (vld_tx) vld_seen++;
      if (vld_tx && rdy_tx) got_q.push_back(d_tx);
      if (done) done_cnt++;
      if (addr != last_addr) begin
        addr_q.push_back(addr);
        last_addr = addr;
      end
    end
  end

  task automatic buildExpected(input logic [1:0] s, input logic [31:0] b, input logic [15:0] n);
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) begin
      w = memWord(s, b + 32'(i));
      for (int k = 7; k >= 0; k--) exp_q.push_back(hexdig[w[k*4 +: 4]]);
      if (i == int'(n) - 1 || (i % WPL) == WPL - 1) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'h20);
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [31:0] b, input logic [15:0] n);
    got_q.delete();
    done_cnt = 0;
    @(negedge clk);
    src   = s;
    base  = b;
    count = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done"}, 32'(done_cnt != 0), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    checkOutput({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic compareStream(input string tag);
    int n;
    checkOutput({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    string s1;
    int    lat;
    int    cyc;

    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src   = 2'd0;
    base  = 32'h0;
    count = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_addr", addr, 32'h0);
    checkOutput("rst_vld", 32'(vld_tx), 32'd0);
    checkOutput("rst_dtx", 32'(d_tx), 32'd0);
    rst = 1'b0;
    last_addr = addr;

    // Two RF words on one line, with the hand-written text.
    $display("[TB] test 1: RF dump of two words");
    s1 = "000000AB 12345678\r\n";
    exp_q.delete();
    for (int i = 0; i < s1.len(); i++) exp_q.push_back(s1[i]);
    applyStimulus(2'd0, 32'h0, 16'd2);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    lat = 0;
    while (!vld_tx && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("t1_latency", 32'(lat), 32'(2 + RD_LAT));
    waitDone("t1");
    compareStream("t1");

    // Five DM words wrap to a second line.
    $display("[TB] test 2: DM dump of five words");
    buildExpected(2'd1, 32'h100, 16'd5);
    applyStimulus(2'd1, 32'h100, 16'd5);
    waitDone("t2");
    checkOutput("t2_bytes", 32'(got_q.size()), 32'd47);
    compareStream("t2");

    // Same dump with a sparse ready.
    $display("[TB] test 3: back-pressure");
    rdy_mode = 1;
    buildExpected(2'd1, 32'h100, 16'd5);
    applyStimulus(2'd1, 32'h100, 16'd5);
    waitDone("t3");
    compareStream("t3");
    rdy_mode = 0;
    @(negedge clk);

    // Zero words: done two cycles after start, nothing sent.
    $display("[TB] test 4: zero count and start while busy");
    vld_seen = 0;
    applyStimulus(2'd0, 32'h50, 16'd0);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    checkOutput("t4_done_early", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_done_end", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t4_no_vld", 32'(vld_seen), 32'd0);
    checkOutput("t4_no_bytes", 32'(got_q.size()), 32'd0);
    checkOutput("t4_done_once", 32'(done_cnt), 32'd1);

    // A second start during a dump must be ignored.
    buildExpected(2'd0, 32'h20, 16'd1);
    applyStimulus(2'd0, 32'h20, 16'd1);
    @(negedge clk);
    src   = 2'd1;
    base  = 32'h40;
    count = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("t4b");
    compareStream("t4b");

    // IM address wrap past the top of the space.
    $display("[TB] test 5: address wrap");
    addr_q.delete();
    buildExpected(2'd2, 32'hFFFF_FFFF, 16'd2);
    applyStimulus(2'd2, 32'hFFFF_FFFF, 16'd2);
    waitDone("t5");
    compareStream("t5");
    checkOutput("t5_addr_cnt", 32'(addr_q.size()), 32'd2);
    if (addr_q.size() >= 2) begin
      checkOutput("t5_addr0", addr_q[0], 32'hFFFF_FFFF);
      checkOutput("t5_addr1", addr_q[1], 32'h0000_0000);
    end

    // Reserved source reads as zero.
    buildExpected(2'd3, 32'h8, 16'd1);
    applyStimulus(2'd3, 32'h8, 16'd1);
    waitDone("t5r");
    compareStream("t5r");

    // Abort during word 1 after three of its digits have gone.
    $display("[TB] test 6: abort and reset mid-dump");
    buildExpected(2'd0, 32'h10, 16'd3);
    while (exp_q.size() > 13) void'(exp_q.pop_back());
    applyStimulus(2'd0, 32'h10, 16'd3);
    cyc = 0;
    while (got_q.size() < 12 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("t6_reach12", 32'(got_q.size()), 32'd12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    waitDone("t6");
    compareStream("t6");

    // Reset in the middle of a dump.
    applyStimulus(2'd1, 32'h200, 16'd4);
    cyc = 0;
    while (!vld_tx && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t7_busy", 32'(busy), 32'd0);
    checkOutput("t7_done", 32'(done), 32'd0);
    checkOutput("t7_addr", addr, 32'h0);
    checkOutput("t7_vld", 32'(vld_tx), 32'd0);
    checkOutput("t7_dtx", 32'(d_tx), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("t7_idle_busy", 32'(busy), 32'd0);
    checkOutput("t7_idle_vld", 32'(vld_tx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
